numled_ctrl: RTL and testbench

- Memory-mapped 8-digit seven-segment display controller.
- Sits directly downstream of the BUS address decoder. It consumes CPU store/load accesses aimed at the digital-tube window, and it drives the board's led_en/led_ca..led_dp pins.
- Holds a 32-bit hex value, a per-digit enable mask and a decimal-point mask.
- Time-multiplexes the eight digits with inter-digit blanking to suppress ghosting.

---
 rtl/numled_ctrl_pkg.sv | 24 ++
 rtl/numled_ctrl_if.sv | 15 +
 rtl/numled_seg_decode.sv | 32 +++
 rtl/numled_ctrl.sv | 143 ++++++++++++++
 tb/tb_numled_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/numled_ctrl_pkg.sv
// Shared constants and types for the seven-segment display controller:
// register offsets, the dark segment pattern and the scan state encoding.
package numled_ctrl_pkg;

  typedef logic [1:0] numled_off_t;
  typedef logic [6:0] seg_t;

  localparam numled_off_t NUMLED_OFF_VALUE = 2'd0;
  localparam numled_off_t NUMLED_OFF_EN    = 2'd1;
  localparam numled_off_t NUMLED_OFF_DP    = 2'd2;

  localparam seg_t        NUMLED_SEG_OFF   = 7'h7F;
  localparam logic [31:0] NUMLED_BASE_ADDR = 32'hFFFF_F000;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/numled_ctrl_if.sv
// CPU-side register window of the display controller, as seen from the
// BUS address decoder (master) and the controller (slave).
interface numled_ctrl_if;
  import numled_ctrl_pkg::*;

  logic        sel;
  numled_off_t addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, addr, we, be, wdata, input rdata);
  modport slave  (input sel, addr, we, be, wdata, output rdata);
endinterface

// File: rtl/numled_seg_decode.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module numled_seg_decode
  import numled_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = NUMLED_SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = NUMLED_SEG_OFF;
    endcase
  end

endmodule

// File: rtl/numled_ctrl.sv
// Memory-mapped 8-digit seven-segment controller: VALUE/EN/DP registers and
// a BLANK/SHOW scan that multiplexes digits with dark gaps against ghosting.
module numled_ctrl
  import numled_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int BLANK_CYC = 16,
  parameter int DIGITS    = 8
) (
  input  logic              clk,
  input  logic              rst,
  numled_ctrl_if.slave      bus,
  output logic [DIGITS-1:0] led_en,
  output logic              led_ca,
  output logic              led_cb,
  output logic              led_cc,
  output logic              led_cd,
  output logic              led_ce,
  output logic              led_cf,
  output logic              led_cg,
  output logic              led_dp
);

  localparam int CNT_W = $clog2(max_int(SCAN_DIV, BLANK_CYC) + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] DIGIT_ONE  = DIGITS'(1);

  logic [31:0]       value;
  logic [DIGITS-1:0] en_mask;
  logic [DIGITS-1:0] dp_mask;

  scan_state_t       state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              latch;

  seg_t              dec_seg;
  seg_t              seg_r;
  logic [DIGITS-1:0] led_en_r;
  logic              dp_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      en_mask <= '1;
      dp_mask <= '0;
    end else if (bus.sel && bus.we) begin
      case (bus.addr)
        NUMLED_OFF_VALUE: begin
          for (int i = 0; i < 4; i++)
            if (bus.be[i]) value[i*8 +: 8] <= bus.wdata[i*8 +: 8];
        end
        NUMLED_OFF_EN: if (bus.be[0]) en_mask <= bus.wdata[DIGITS-1:0];
        NUMLED_OFF_DP: if (bus.be[0]) dp_mask <= bus.wdata[DIGITS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        NUMLED_OFF_VALUE: bus.rdata = value;
        NUMLED_OFF_EN:    bus.rdata[DIGITS-1:0] = en_mask;
        NUMLED_OFF_DP:    bus.rdata[DIGITS-1:0] = dp_mask;
        default:          bus.rdata = '0;
      endcase
    end
  end

  numled_seg_decode u_dec (
    .nibble (value[{idx, 2'b00} +: 4]),
    .seg    (dec_seg)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    latch   = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = ST_SHOW;
          cnt_n   = '0;
          latch   = 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end
      end
      default: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
      end
    endcase
  end

  // Pins are registered and loaded together with the state, so the pattern
  // sampled at the latch edge (pre-write registers) holds for the whole slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_BLANK;
      cnt      <= '0;
      idx      <= '0;
      led_en_r <= '1;
      seg_r    <= NUMLED_SEG_OFF;
      dp_r     <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      if (latch) begin
        seg_r    <= dec_seg;
        dp_r     <= ~dp_mask[idx];
        led_en_r <= en_mask[idx] ? ~(DIGIT_ONE << idx) : '1;
      end else if (state_n == ST_BLANK) begin
        led_en_r <= '1;
        seg_r    <= NUMLED_SEG_OFF;
        dp_r     <= 1'b1;
      end
    end
  end

  assign led_en = led_en_r;
  assign led_ca = seg_r[0];
  assign led_cb = seg_r[1];
  assign led_cc = seg_r[2];
  assign led_cd = seg_r[3];
  assign led_ce = seg_r[4];
  assign led_cf = seg_r[5];
  assign led_cg = seg_r[6];
  assign led_dp = dp_r;

endmodule

// File: tb/tb_numled_ctrl.sv
// Bench for numled_ctrl: register table, slot scoreboard on the pins, and a
// second instance with no blanking to check the single dark cycle.
module tb_numled_ctrl;
  import numled_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  numled_ctrl_if bus_a ();
  numled_ctrl_if bus_b ();

  logic [7:0] led_en, led_en_b;
  logic ca, cb, cc, cd, ce, cf, cg, dp;
  logic ca_b, cb_b, cc_b, cd_b, ce_b, cf_b, cg_b, dp_b;
  logic [6:0] segs, segs_b;
  assign segs   = {cg, cf, ce, cd, cc, cb, ca};
  assign segs_b = {cg_b, cf_b, ce_b, cd_b, cc_b, cb_b, ca_b};

  numled_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus_a), .led_en(led_en),
    .led_ca(ca), .led_cb(cb), .led_cc(cc), .led_cd(cd), .led_ce(ce),
    .led_cf(cf), .led_cg(cg), .led_dp(dp));

  numled_ctrl #(.SCAN_DIV(4), .BLANK_CYC(0), .DIGITS(8)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b), .led_en(led_en_b),
    .led_ca(ca_b), .led_cb(cb_b), .led_cc(cc_b), .led_cd(cd_b), .led_ce(ce_b),
    .led_cf(cf_b), .led_cg(cg_b), .led_dp(dp_b));

  int checks = 0;
  int failures = 0;
  logic [6:0] seg_tab [16];
  logic [31:0] q [$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Slot monitor: a slot is a run of samples with anything lit.
  int   cyc = 0;
  int   mon_slot = -1;
  logic mon_lit = 1'b0;
  int   dark = 0, gap = 0, run_len = 0;
  logic same;
  logic lit;
  logic [7:0] cap_en;
  logic [6:0] cap_seg;
  logic cap_dp;
  logic [31:0] exp_sig;
  int start_cyc [16];

  always @(posedge clk) begin
    #1;
    cyc++;
    lit = (led_en != 8'hFF) || (segs != 7'h7F) || !dp;
    if (rst) begin
      mon_lit  = 1'b0;
      mon_slot = -1;
      dark     = 1;
    end else if (lit) begin
      if (!mon_lit) begin
        mon_slot++;
        gap = dark; cap_en = led_en; cap_seg = segs; cap_dp = dp;
        run_len = 1; same = 1'b1;
        if (mon_slot < 16) start_cyc[mon_slot] = cyc;
      end else begin
        run_len++;
        if (led_en != cap_en || segs != cap_seg || dp != cap_dp) same = 1'b0;
      end
      mon_lit = 1'b1;
      dark = 0;
    end else begin
      if (mon_lit && q.size() > 0) begin
        exp_sig = q.pop_front();
        check32($sformatf("slot%0d", mon_slot),
                {cap_en, cap_seg, cap_dp, same ? 8'(run_len) : 8'hEE, 8'(gap)}, exp_sig);
      end
      mon_lit = 1'b0;
      dark++;
    end
  end

  // Gap/length tracker for the no-blanking instance.
  int b_slots = 0, b_dark = 0, b_run = 0;
  int b_gap_min = 999, b_gap_max = 0, b_len_min = 999, b_len_max = 0;
  logic b_lit, b_was_lit = 1'b0;
  always @(posedge clk) begin
    #1;
    b_lit = (led_en_b != 8'hFF) || (segs_b != 7'h7F) || !dp_b;
    if (rst_b) begin
      b_was_lit = 1'b0; b_dark = 1; b_run = 0;
    end else if (b_lit) begin
      if (!b_was_lit && b_slots > 0) begin
        if (b_dark < b_gap_min) b_gap_min = b_dark;
        if (b_dark > b_gap_max) b_gap_max = b_dark;
      end
      b_run++; b_was_lit = 1'b1; b_dark = 0;
    end else begin
      if (b_was_lit) begin
        b_slots++;
        if (b_run < b_len_min) b_len_min = b_run;
        if (b_run > b_len_max) b_len_max = b_run;
      end
      b_run = 0; b_was_lit = 1'b0; b_dark++;
    end
  end

  task automatic push_slot(input int i, input logic [3:0] nib, input logic [7:0] en, input logic [7:0] dpm);
    logic [7:0] en_exp;
    en_exp = en[i] ? ~(8'h01 << i) : 8'hFF;
    q.push_back({en_exp, seg_tab[nib], ~dpm[i], 8'd4, 8'd3});
  endtask

  task automatic push_pass(input logic [31:0] v, input logic [7:0] en, input logic [7:0] dpm);
    for (int i = 0; i < 8; i++) push_slot(i, v[i*4 +: 4], en, dpm);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    bus_a.sel = 1'b1; bus_a.we = 1'b1; bus_a.addr = a; bus_a.be = b; bus_a.wdata = d;
    @(negedge clk);
    bus_a.sel = 1'b0; bus_a.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_a.sel = 1'b1; bus_a.we = 1'b0; bus_a.addr = a;
    #1;
    check32(name, bus_a.rdata, exp);
    bus_a.sel = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 400) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: %0d slots outstanding, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic wait_slot(input int s, input string name);
    int n = 0;
    while (!(mon_slot == s && mon_lit) && n < 200) begin @(negedge clk); n++; end
    if (!(mon_slot == s && mon_lit)) begin
      checks++; failures++;
      $display("FAIL %s_wait: slot %0d not reached (at %0d)", name, s, mon_slot);
    end
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;
  reg_vec_t vec [8];

  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    vec[0] = '{2'd0, 4'hF,    32'h8765_43A1, 32'h8765_43A1};
    vec[1] = '{2'd0, 4'b0010, 32'hFFFF_FF00, 32'h8765_FFA1};
    vec[2] = '{2'd0, 4'b1001, 32'h1122_3344, 32'h1165_FF44};
    vec[3] = '{2'd1, 4'hF,    32'hFFFF_FF05, 32'h0000_0005};
    vec[4] = '{2'd1, 4'b1110, 32'h0000_00AA, 32'h0000_0005};
    vec[5] = '{2'd2, 4'b0001, 32'h0000_0104, 32'h0000_0004};
    vec[6] = '{2'd3, 4'hF,    32'hFFFF_FFFF, 32'h0000_0000};
    vec[7] = '{2'd0, 4'h0,    32'hDEAD_BEEF, 32'h1165_FF44};

    bus_a.sel = 0; bus_a.we = 0; bus_a.addr = 0; bus_a.be = 0; bus_a.wdata = 0;
    bus_b.sel = 0; bus_b.we = 0; bus_b.addr = 0; bus_b.be = 0; bus_b.wdata = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;

    // Register map
    do_reset();
    bus_read(2'd0, 32'h0, "rst_value");
    bus_read(2'd1, 32'hFF, "rst_en");
    for (int i = 0; i < 8; i++) begin
      bus_write(vec[i].addr, vec[i].be, vec[i].wdata);
      bus_read(vec[i].addr, vec[i].exp, $sformatf("regvec%0d", i));
    end
    bus_read(2'd1, 32'h5, "off3_no_effect_en");
    bus_read(2'd2, 32'h4, "off3_no_effect_dp");
    bus_a.sel = 1'b0; bus_a.addr = 2'd0; #1;
    check32("read_unselected", bus_a.rdata, 32'h0);

    // Idle after reset: all zeros, 3 dark cycles, 56-cycle period
    do_reset();
    push_pass(32'h0, 8'hFF, 8'h00);
    drain("idle");
    wait_slot(8, "period");
    check32("scan_period", 32'(start_cyc[8] - start_cyc[0]), 32'd56);

    // Full value
    do_reset();
    bus_write(2'd0, 4'hF, 32'h8765_43A1);
    bus_read(2'd0, 32'h8765_43A1, "value_read");
    push_pass(32'h8765_43A1, 8'hFF, 8'h00);
    drain("value");

    // Byte write
    do_reset();
    bus_write(2'd0, 4'b0010, 32'hFFFF_FF00);
    bus_read(2'd0, 32'h0000_FF00, "byte_read");
    push_pass(32'h0000_FF00, 8'hFF, 8'h00);
    drain("byte");

    // Enable and decimal-point masks
    do_reset();
    bus_write(2'd1, 4'h1, 32'h0000_0005);
    bus_write(2'd2, 4'h1, 32'h0000_0004);
    push_pass(32'h0, 8'h05, 8'h04);
    drain("masks");

    // Write during digit 3's slot
    do_reset();
    for (int i = 0; i < 4; i++) push_slot(i, 4'h0, 8'hFF, 8'h00);
    for (int i = 4; i < 8; i++) push_slot(i, 4'h9, 8'hFF, 8'h00);
    push_pass(32'h9999_9999, 8'hFF, 8'h00);
    wait_slot(3, "midwrite");
    bus_write(2'd0, 4'hF, 32'h9999_9999);
    drain("midwrite");

    // Reset in the middle of digit 5's slot
    do_reset();
    bus_write(2'd0, 4'hF, 32'h1234_5678);
    bus_write(2'd2, 4'h1, 32'h0000_0020);
    wait_slot(5, "midreset");
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midreset_dark", {15'h0, led_en, segs, dp}, {15'h0, 8'hFF, 7'h7F, 1'b1});
    @(negedge clk); rst = 1'b0;
    bus_read(2'd0, 32'h0, "midreset_value");
    bus_read(2'd1, 32'hFF, "midreset_en");
    bus_read(2'd2, 32'h0, "midreset_dp");
    push_pass(32'h0, 8'hFF, 8'h00);
    drain("midreset");

    // No-blanking instance
    check32("b_enough_slots", 32'(b_slots >= 8), 32'd1);
    check32("b_gap_min_max", {16'(b_gap_min), 16'(b_gap_max)}, {16'd1, 16'd1});
    check32("b_len_min_max", {16'(b_len_min), 16'(b_len_max)}, {16'd4, 16'd4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
